// File: rtl/vs_pkg.sv
// Shared constants and types for the scalar/vector register file.
// VL elements of SEW bits form one vector register; each architectural
// register owns a CNT_W-bit pending-write counter.
package vs_pkg;
  localparam int VL        = 8;
  localparam int SEW       = 32;
  localparam int VLEN_BITS = VL * SEW;
  localparam int NUM_REGS  = 32;
  localparam int CNT_W     = 2;
  localparam int ADDR_W    = 5;

  typedef logic [ADDR_W-1:0]    addr_t;
  typedef logic [SEW-1:0]       sreg_t;
  typedef logic [VLEN_BITS-1:0] vreg_t;
  typedef logic [CNT_W-1:0]     cnt_t;

  localparam addr_t REG_X0 = '0;
endpackage

// File: rtl/vs_reg_file_if.sv
// Bundle of write-back commit, decode read and issue signals.
// slave  : register file side (consumes commits/reads/issues, drives operands,
//          stall and the sticky underflow flag)
// master : pipeline side (write-back + decode/issue)
interface vs_reg_file_if;
  import vs_pkg::*;

  // write-back commit
  logic  write;
  logic  is_s_i;
  logic  is_v_i;
  addr_t rd_i;
  addr_t vd_i;
  sreg_t data_s_i;
  vreg_t data_v_i;
  // operand reads
  addr_t rs1, rs2;
  addr_t vs1, vs2, vs3;
  logic [1:0] src_s_en;
  logic [2:0] src_v_en;
  sreg_t rs1_data, rs2_data;
  vreg_t vs1_data, vs2_data, vs3_data;
  // issue
  logic  issue_valid;
  logic  issue_is_s;
  logic  issue_is_v;
  addr_t issue_rd;
  addr_t issue_vd;
  // status
  logic  stall_o;
  logic  underflow_err;

  modport slave (
    input  write, is_s_i, is_v_i, rd_i, vd_i, data_s_i, data_v_i,
    input  rs1, rs2, vs1, vs2, vs3, src_s_en, src_v_en,
    input  issue_valid, issue_is_s, issue_is_v, issue_rd, issue_vd,
    output rs1_data, rs2_data, vs1_data, vs2_data, vs3_data,
    output stall_o, underflow_err
  );

  modport master (
    output write, is_s_i, is_v_i, rd_i, vd_i, data_s_i, data_v_i,
    output rs1, rs2, vs1, vs2, vs3, src_s_en, src_v_en,
    output issue_valid, issue_is_s, issue_is_v, issue_rd, issue_vd,
    input  rs1_data, rs2_data, vs1_data, vs2_data, vs3_data,
    input  stall_o, underflow_err
  );
endinterface

// File: rtl/sb_counter.sv
// One pending-write counter of the scoreboard.
// Ports: clk, rst_n; inc (accepted issue), dec (commit);
//        count, full (at max), busy (pending and not retired this cycle),
//        underflow (commit while count is 0, combinational pulse).
module sb_counter
  import vs_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output cnt_t count,
  output logic full,
  output logic busy,
  output logic underflow
);
  cnt_t count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (inc && !dec && !full) begin
      count_reg <= count_reg + cnt_t'(1);
    end else if (dec && !inc && count_reg != '0) begin
      count_reg <= count_reg - cnt_t'(1);
    end
  end

  assign count     = count_reg;
  assign full      = &count_reg;
  assign underflow = dec && (count_reg == '0);
  // The last outstanding write retiring this cycle is forwarded by the
  // read bypass, so it no longer blocks its consumers.
  assign busy      = (count_reg != '0) && !((count_reg == cnt_t'(1)) && dec);
endmodule

// File: rtl/vs_reg_file.sv
// Scalar + vector architectural register file with pending-write scoreboard.
// Ports: clk, rst_n (async, active low); rf = vs_reg_file_if.slave carrying
//        commits from write-back, operand reads and issue requests from
//        decode, and returning operands, stall_o and underflow_err.
module vs_reg_file
  import vs_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  vs_reg_file_if.slave rf
);
  sreg_t s_mem [NUM_REGS];
  vreg_t v_mem [NUM_REGS];

  logic [NUM_REGS-1:0] s_inc, s_dec, s_full, s_busy, s_uf;
  logic [NUM_REGS-1:0] v_inc, v_dec, v_full, v_busy, v_uf;
  // Counts are not needed by the datapath; kept for debug probing.
  cnt_t s_count_unused [NUM_REGS];
  cnt_t v_count_unused [NUM_REGS];

  logic s_commit, v_commit, accept, stall;
  logic s_src_busy, v_src_busy, dest_full;
  logic underflow_reg;

  // x0 commits are dropped entirely: no storage update, no counter retire.
  assign s_commit = rf.write && rf.is_s_i && (rf.rd_i != REG_X0);
  assign v_commit = rf.write && rf.is_v_i;
  assign accept   = rf.issue_valid && !stall;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
    assign s_dec[gi] = s_commit && (rf.rd_i == addr_t'(gi));
    assign v_dec[gi] = v_commit && (rf.vd_i == addr_t'(gi));
    assign v_inc[gi] = accept && rf.issue_is_v && (rf.issue_vd == addr_t'(gi));
    if (gi == 0) begin : g_x0
      assign s_inc[gi] = 1'b0;
    end else begin : g_xn
      assign s_inc[gi] = accept && rf.issue_is_s && (rf.issue_rd == addr_t'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_mem[gi] <= '0;
      end else if (s_dec[gi]) begin
        s_mem[gi] <= rf.data_s_i;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_mem[gi] <= '0;
      end else if (v_dec[gi]) begin
        v_mem[gi] <= rf.data_v_i;
      end
    end

    sb_counter u_s_cnt (
      .clk(clk), .rst_n(rst_n), .inc(s_inc[gi]), .dec(s_dec[gi]),
      .count(s_count_unused[gi]), .full(s_full[gi]), .busy(s_busy[gi]),
      .underflow(s_uf[gi])
    );

    sb_counter u_v_cnt (
      .clk(clk), .rst_n(rst_n), .inc(v_inc[gi]), .dec(v_dec[gi]),
      .count(v_count_unused[gi]), .full(v_full[gi]), .busy(v_busy[gi]),
      .underflow(v_uf[gi])
    );
  end

  // Combinational reads with same-cycle commit bypass; x0 reads as zero.
  assign rf.rs1_data = (rf.rs1 == REG_X0) ? '0 :
                       (s_commit && rf.rd_i == rf.rs1) ? rf.data_s_i : s_mem[rf.rs1];
  assign rf.rs2_data = (rf.rs2 == REG_X0) ? '0 :
                       (s_commit && rf.rd_i == rf.rs2) ? rf.data_s_i : s_mem[rf.rs2];
  assign rf.vs1_data = (v_commit && rf.vd_i == rf.vs1) ? rf.data_v_i : v_mem[rf.vs1];
  assign rf.vs2_data = (v_commit && rf.vd_i == rf.vs2) ? rf.data_v_i : v_mem[rf.vs2];
  assign rf.vs3_data = (v_commit && rf.vd_i == rf.vs3) ? rf.data_v_i : v_mem[rf.vs3];

  assign s_src_busy = (rf.src_s_en[0] && rf.rs1 != REG_X0 && s_busy[rf.rs1]) ||
                      (rf.src_s_en[1] && rf.rs2 != REG_X0 && s_busy[rf.rs2]);
  assign v_src_busy = (rf.src_v_en[0] && v_busy[rf.vs1]) ||
                      (rf.src_v_en[1] && v_busy[rf.vs2]) ||
                      (rf.src_v_en[2] && v_busy[rf.vs3]);
  // A saturated destination can still take an issue when a commit to it
  // frees a slot in the same cycle.
  assign dest_full  = rf.issue_valid &&
                      ((rf.issue_is_s && rf.issue_rd != REG_X0 &&
                        s_full[rf.issue_rd] && !s_dec[rf.issue_rd]) ||
                       (rf.issue_is_v && v_full[rf.issue_vd] && !v_dec[rf.issue_vd]));
  assign stall      = s_src_busy || v_src_busy || dest_full;
  assign rf.stall_o = stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_reg <= 1'b0;
    end else if ((|s_uf) || (|v_uf)) begin
      underflow_reg <= 1'b1;
    end
  end

  assign rf.underflow_err = underflow_reg;
endmodule

// File: tb/tb_vs_reg_file.sv
module tb_vs_reg_file;
  import vs_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  vs_reg_file_if bus ();

  vs_reg_file dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rf   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("vec %0d %s ok (%h)", n_vec, tag, obs);
    end
  endtask

  task automatic idle();
    bus.write = 0; bus.is_s_i = 0; bus.is_v_i = 0;
    bus.rd_i = 0; bus.vd_i = 0; bus.data_s_i = 0; bus.data_v_i = '0;
    bus.rs1 = 0; bus.rs2 = 0; bus.vs1 = 0; bus.vs2 = 0; bus.vs3 = 0;
    bus.src_s_en = 0; bus.src_v_en = 0;
    bus.issue_valid = 0; bus.issue_is_s = 0; bus.issue_is_v = 0;
    bus.issue_rd = 0; bus.issue_vd = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vreg_t vpat1, vpat2;
  addr_t a;

  initial begin
    n_vec = 0;
    n_bad = 0;
    for (int e = 0; e < VL; e++) begin
      vpat1[e*SEW +: SEW] = SEW'(e + 1);
      vpat2[e*SEW +: SEW] = 32'hCAFE0000 + SEW'(e * 16 + 5);
    end

    // Reset: everything reads zero
    idle();
    rst_n = 0;
    #3;
    for (int i = 0; i < 3; i++) begin
      a = (i == 0) ? 5'd0 : (i == 1) ? 5'd5 : 5'd31;
      bus.rs1 = a; bus.rs2 = a; bus.vs1 = a; bus.vs2 = a; bus.vs3 = a;
      bus.src_s_en = 2'b11; bus.src_v_en = 3'b111;
      #1;
      check("rst_rs1", bus.rs1_data, 0);
      check("rst_vs3", bus.vs3_data, 0);
      check("rst_stall", bus.stall_o, 0);
    end
    check("rst_uf", bus.underflow_err, 0);
    @(negedge clk);
    rst_n = 1;
    step();

    // Scalar commit with same-cycle bypass
    idle(); bus.issue_valid = 1; bus.issue_is_s = 1; bus.issue_rd = 5;
    #1 check("iss_x5_stall", bus.stall_o, 0);
    step();
    idle(); bus.write = 1; bus.is_s_i = 1; bus.rd_i = 5; bus.data_s_i = 32'hDEADBEEF;
    bus.rs1 = 5; bus.src_s_en = 2'b01;
    #1 check("x5_bypass", bus.rs1_data, 32'hDEADBEEF);
    check("x5_bypass_stall", bus.stall_o, 0);
    step();
    idle(); bus.rs1 = 5; bus.rs2 = 5; bus.src_s_en = 2'b11;
    #1 check("x5_held_rs1", bus.rs1_data, 32'hDEADBEEF);
    check("x5_held_rs2", bus.rs2_data, 32'hDEADBEEF);
    check("x5_held_stall", bus.stall_o, 0);

    // x0 writes discarded
    idle(); bus.write = 1; bus.is_s_i = 1; bus.rd_i = 0; bus.data_s_i = 32'h1234;
    bus.rs1 = 0; bus.src_s_en = 2'b01;
    #1 check("x0_bypass", bus.rs1_data, 0);
    step();
    idle(); bus.rs1 = 0;
    #1 check("x0_held", bus.rs1_data, 0);
    check("x0_no_uf", bus.underflow_err, 0);

    // Vector commit with bypass on vs3
    idle(); bus.issue_valid = 1; bus.issue_is_v = 1; bus.issue_vd = 3;
    step();
    idle(); bus.write = 1; bus.is_v_i = 1; bus.vd_i = 3; bus.data_v_i = vpat1;
    bus.vs3 = 3; bus.src_v_en = 3'b100;
    #1 check("v3_bypass", bus.vs3_data, vpat1);
    check("v3_bypass_stall", bus.stall_o, 0);
    step();
    idle(); bus.vs3 = 3;
    #1 check("v3_held", bus.vs3_data, vpat1);

    // RAW hazard on v4
    idle(); bus.issue_valid = 1; bus.issue_is_v = 1; bus.issue_vd = 4;
    #1 check("iss_v4_stall", bus.stall_o, 0);
    step();
    idle(); bus.vs1 = 4; bus.src_v_en = 3'b001;
    #1 check("v4_busy", bus.stall_o, 1);
    step();
    check("v4_busy_hold", bus.stall_o, 1);
    bus.write = 1; bus.is_v_i = 1; bus.vd_i = 4; bus.data_v_i = vpat2;
    #1 check("v4_commit_stall", bus.stall_o, 0);
    check("v4_commit_data", bus.vs1_data, vpat2);
    step();
    idle(); bus.vs1 = 4; bus.src_v_en = 3'b001;
    #1 check("v4_after_stall", bus.stall_o, 0);
    check("v4_after_data", bus.vs1_data, vpat2);

    // Counter saturation on x7
    for (int k = 0; k < 3; k++) begin
      idle(); bus.issue_valid = 1; bus.issue_is_s = 1; bus.issue_rd = 7;
      #1 check("x7_issue", bus.stall_o, 0);
      step();
    end
    idle(); bus.issue_valid = 1; bus.issue_is_s = 1; bus.issue_rd = 7;
    #1 check("x7_full", bus.stall_o, 1);
    step();
    check("x7_full_hold", bus.stall_o, 1);
    bus.write = 1; bus.is_s_i = 1; bus.rd_i = 7; bus.data_s_i = 32'h77;
    #1 check("x7_full_commit", bus.stall_o, 0);
    step();
    idle(); bus.issue_valid = 1; bus.issue_is_s = 1; bus.issue_rd = 7;
    #1 check("x7_still_full", bus.stall_o, 1);
    idle(); bus.rs1 = 7; bus.src_s_en = 2'b01;
    #1 check("x7_src_busy", bus.stall_o, 1);
    for (int k = 0; k < 3; k++) begin
      idle(); bus.write = 1; bus.is_s_i = 1; bus.rd_i = 7; bus.data_s_i = 32'h70 + k;
      step();
    end
    idle(); bus.rs1 = 7; bus.src_s_en = 2'b01;
    #1 check("x7_drained", bus.stall_o, 0);
    check("x7_data", bus.rs1_data, 32'h72);
    check("x7_no_uf", bus.underflow_err, 0);

    // Underflow: commit with nothing pending
    idle(); bus.write = 1; bus.is_s_i = 1; bus.rd_i = 9; bus.data_s_i = 32'h99;
    #1 check("uf_before", bus.underflow_err, 0);
    step();
    idle();
    #1 check("uf_set", bus.underflow_err, 1);
    step();
    step();
    check("uf_sticky", bus.underflow_err, 1);

    // Reset clears sticky flag and storage
    bus.rs1 = 7; bus.src_s_en = 2'b01;
    rst_n = 0;
    #1 check("rst2_uf", bus.underflow_err, 0);
    check("rst2_rs1", bus.rs1_data, 0);
    check("rst2_stall", bus.stall_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/vs_reg_file.md
# vs_reg_file

Scalar and vector architectural register file that consumes the write-back stage's outputs (write enable, scalar/vector flags, rd/vd, scalar/vector data) and serves operand reads to decode. It contains a per-register pending-write scoreboard that decode sets on issue and write-back clears on commit. The scoreboard drives a hazard stall. Sits between write-back (write side) and decode/issue (read and issue side).

## Interface
- VL, 8, elements per vector register
- SEW, 32, element width in bits; vector register width is VL*SEW
- CNT_W, 2, width of each per-register pending-write counter

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- write  in  1  write-back commit strobe
- is_s_i / is_v_i  in  1 each  commit targets the scalar / vector file
- rd_i / vd_i  in  5 each  scalar / vector destination
- data_s_i  in  32  scalar write data
- data_v_i  in  VL*SEW  vector write data
- rs1, rs2  in  5 each  scalar read addresses
- vs1, vs2, vs3  in  5 each  vector read addresses; vs3 is store data
- src_s_en  in  2  bit0 = rs1 used, bit1 = rs2 used
- src_v_en  in  3  bits 0..2 = vs1..vs3 used
- rs1_data, rs2_data  out  32 each  scalar operands
- vs1_data, vs2_data, vs3_data  out  VL*SEW each  vector operands
- issue_valid  in  1  decode issues an instruction this cycle
- issue_is_s / issue_is_v  in  1 each  issued instruction writes scalar / vector
- issue_rd / issue_vd  in  5 each  issued destinations
- stall_o  out  1  source hazard or destination counter full
- underflow_err  out  1  sticky; commit to a register whose counter is 0

## Operation
- Storage: 32×32 scalar and 32×(VL*SEW) vector registers, plus one CNT_W-bit pending counter per register per file (64 counters).
- Commit: write&&is_s_i writes rd_i. write&&is_v_i writes vd_i. Both flags set writes both files. write=0 ignores all data.
- x0: scalar writes to rd_i=0 are discarded, reads of x0 return 0, and x0 counter is never incremented. v0 is an ordinary register.
- Reads are combinational. On a same-cycle commit to the read address, the read returns the incoming data (bypass). Otherwise it returns stored data.
- Counters, per register r:
  - inc = accepted issue targeting r. An issue is accepted when issue_valid && !stall_o.
  - dec = commit targeting r.
  - inc&&dec: counter unchanged.
  - dec with counter 0: counter stays 0 and underflow_err is set. Only reset clears it.
- busy(r) = counter != 0, except when counter==1 and a same-cycle commit to r is present (bypass covers it).
- stall_o = OR of these conditions:
  - any enabled scalar source is busy; x0 is never busy
  - any enabled vector source is busy
  - issue_valid and the targeted destination counter == 2^CNT_W−1, unless a same-cycle commit decrements that counter
- When stall_o=1, an issue is not accepted and no counter increments.
- Reset: all registers, counters and underflow_err go to 0. Therefore all read outputs are 0 and stall_o=0.

## Timing
- Commit latency: data is written at the rising edge where write=1; the same-cycle read already returns it via bypass.
- Issue latency: the counter increments at the edge of an accepted issue. A dependent source reads busy from the next cycle.
- stall_o is combinational from the counters plus current write/issue inputs. There is no registered output path.
- Reset mid-operation: pending counts are lost. Commits arriving after reset for pre-reset issues trigger underflow_err. The integrating pipeline flushes on reset.

## Structure
- Shared package vs_pkg holds: VL, SEW, VLEN_BITS = VL*SEW, NUM_REGS = 32, CNT_W, and REG_X0 = 0.
- Sub-module sb_counter is one saturating up/down counter with inc, dec, count, full, busy and underflow outputs. It is instantiated 32 times per file via generate.

## Test plan
- Reset, then read all addresses → all outputs 0, stall_o=0, underflow_err=0.
- Commit write=1, is_s_i=1, rd_i=5, data 0xDEADBEEF with rs1=5 in the same cycle → rs1_data=0xDEADBEEF that cycle and afterwards. Commit rd_i=0 with 0x1234 → rs1=0 reads 0.
- Commit is_v_i=1, vd_i=3 with data_v_i = elements 0..7 = 1..8, while vs3=3 → vs3_data is bypassed at once and is still held after write drops.
- Issue issue_is_v, issue_vd=4; next cycle src_v_en[0]=1, vs1=4 → stall_o=1. Commit vd_i=4 → stall_o=0 in the commit cycle and vs1_data equals the commit data.
- Three accepted issues to rd=7 → counter=3. A fourth issue → stall_o=1 and count stays 3. Fourth issue together with a commit to rd=7 → accepted, count stays 3.
- Commit to rd=9 with no prior issue → underflow_err=1 next cycle and remains set until rst_n is asserted.
